// File: rtl/lc3b_types.sv
// Shared LC-3b types: the bus word, the memory responder state encoding, and the
// byte-lane masking helper used on the read return path.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DRIVE,
    WR,
    RELEASE
  } lc3b_mem_state;

  // Width of the read wait counter; covers READ_LATENCY up to 7.
  localparam int LAT_W = 3;

  // A disabled lane (strobe high) returns zeros instead of stored data.
  function automatic lc3b_word lane_mask(input lc3b_word w, input logic ub_n, input logic lb_n);
    lane_mask = {(ub_n ? 8'h00 : w[15:8]), (lb_n ? 8'h00 : w[7:0])};
  endfunction

endpackage

// File: rtl/tri_buff.sv
// Tri-state driver: passes d onto q while en is high, otherwise floats q.
module tri_buff #(
  parameter int WIDTH = 16
) (
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output wire  [WIDTH-1:0] q
);

  assign q = en ? d : {WIDTH{1'bz}};

endmodule

// File: rtl/sram_responder.sv
// SRAM-style responder for the LC-3b external bus: decodes active-low strobes,
// stores words with byte-lane enables and returns read data after a fixed wait.
module sram_responder
  import lc3b_types::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [19:0] ADDR,
  inout  wire  [15:0] Data,
  input  logic        CE_N,
  input  logic        OE_N,
  input  logic        WE_N,
  input  logic        UB_N,
  input  logic        LB_N,
  output logic        R,
  output logic        busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  lc3b_word mem [DEPTH];

  lc3b_mem_state          state_q, state_d;
  logic [LAT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  lc3b_word               rd_data_q, rd_data_d;
  logic                   r_q, r_d;
  logic                   busy_q, busy_d;
  logic                   drive_en;
  logic                   mem_we;
  logic                   addr_unused;

  // Upper address bits alias onto the stored range.
  assign addr_unused = ^ADDR[19:ADDR_WIDTH];

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    case (state_q)
      IDLE: begin
        if (!CE_N) begin
          if (!WE_N) begin
            state_d = WR;
            addr_d  = ADDR[ADDR_WIDTH-1:0];
          end else if (!OE_N) begin
            state_d    = RD_WAIT;
            addr_d     = ADDR[ADDR_WIDTH-1:0];
            wait_cnt_d = LAT_W'(READ_LATENCY - 1);
          end
        end
      end
      RD_WAIT: begin
        if (CE_N || OE_N) begin
          state_d = IDLE;
        end else if (wait_cnt_q == '0) begin
          state_d = RD_DRIVE;
        end else begin
          wait_cnt_d = wait_cnt_q - LAT_W'(1);
        end
      end
      RD_DRIVE: begin
        if (!WE_N) begin
          state_d = RELEASE;
        end else if (CE_N || OE_N) begin
          state_d = IDLE;
        end
      end
      WR: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        // Held strobes park here so they cannot start a second access.
        if (CE_N || (WE_N && OE_N)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    r_d       = (state_d == RD_DRIVE) || (state_d == WR);
    busy_d    = (state_d != IDLE);
    rd_data_d = lane_mask(mem[addr_q], UB_N, LB_N);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      r_q        <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      r_q        <= r_d;
      busy_q     <= busy_d;
    end
  end

  always_ff @(posedge Clk) begin
    addr_q    <= addr_d;
    rd_data_q <= rd_data_d;
  end

  // A reset landing on the WR edge suppresses the commit.
  assign mem_we = (state_q == WR) && !Reset;

  always_ff @(posedge Clk) begin
    if (mem_we) begin
      if (!UB_N) mem[addr_q][15:8] <= Data[15:8];
      if (!LB_N) mem[addr_q][7:0]  <= Data[7:0];
    end
  end

  // A falling WE_N releases the bus immediately to avoid fighting the writer.
  assign drive_en = (state_q == RD_DRIVE) && WE_N;

  tri_buff #(.WIDTH(16)) u_data_drv (
    .en (drive_en),
    .d  (rd_data_q),
    .q  (Data)
  );

  assign R    = r_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: one instance at the default latency and one
// at READ_LATENCY=4 share all strobes; each has its own pulled-up data bus.
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] addr;
  logic        ce_n, oe_n, we_n, ub_n, lb_n;
  logic        tb_en;
  logic [15:0] tb_val;
  wire  [15:0] data_a;
  wire  [15:0] data_b;
  logic        r_a, busy_a, r_b, busy_b;

  int n_vec = 0;
  int n_bad = 0;

  // Released buses read as all ones.
  localparam logic [15:0] BUS_Z = 16'hFFFF;

  pullup (data_a);
  pullup (data_b);

  assign data_a = tb_en ? tb_val : 16'hzzzz;
  assign data_b = tb_en ? tb_val : 16'hzzzz;

  always #5 clk = ~clk;

  sram_responder #(.ADDR_WIDTH(8), .READ_LATENCY(2)) dut_a (
    .Clk(clk), .Reset(rst), .ADDR(addr), .Data(data_a),
    .CE_N(ce_n), .OE_N(oe_n), .WE_N(we_n), .UB_N(ub_n), .LB_N(lb_n),
    .R(r_a), .busy(busy_a)
  );

  sram_responder #(.ADDR_WIDTH(8), .READ_LATENCY(4)) dut_b (
    .Clk(clk), .Reset(rst), .ADDR(addr), .Data(data_b),
    .CE_N(ce_n), .OE_N(oe_n), .WE_N(we_n), .UB_N(ub_n), .LB_N(lb_n),
    .R(r_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic strobes_off();
    ce_n  = 1'b1;
    oe_n  = 1'b1;
    we_n  = 1'b1;
    tb_en = 1'b0;
  endtask

  task automatic wr(input logic [19:0] a, input logic [15:0] v, input logic ub, input logic lb);
    addr = a; tb_val = v; tb_en = 1'b1; ub_n = ub; lb_n = lb;
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1;
    @(negedge clk);
    chk("wr_r_a", 16'(r_a), 16'd1);
    chk("wr_r_b", 16'(r_b), 16'd1);
    chk("wr_busy_a", 16'(busy_a), 16'd1);
    @(negedge clk);
    chk("wr_r_off_a", 16'(r_a), 16'd0);
    chk("wr_release_busy_a", 16'(busy_a), 16'd1);
    strobes_off();
    @(negedge clk);
    chk("wr_idle_a", 16'(busy_a), 16'd0);
    chk("wr_idle_b", 16'(busy_b), 16'd0);
  endtask

  task automatic rd(input logic [19:0] a, input logic ub, input logic lb, input logic [15:0] exp);
    addr = a; ub_n = ub; lb_n = lb; tb_en = 1'b0;
    ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk("rd_r_a", 16'(r_a), (c >= 3) ? 16'd1 : 16'd0);
      chk("rd_data_a", data_a, (c >= 3) ? exp : BUS_Z);
      chk("rd_r_b", 16'(r_b), (c >= 5) ? 16'd1 : 16'd0);
      chk("rd_data_b", data_b, (c >= 5) ? exp : BUS_Z);
    end
    strobes_off();
    @(negedge clk);
    chk("rd_idle_a", 16'(busy_a), 16'd0);
    chk("rd_idle_b", 16'(busy_b), 16'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1; addr = '0; ub_n = 1'b0; lb_n = 1'b0; tb_val = '0;
    strobes_off();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_r_a", 16'(r_a), 16'd0);
      chk("rst_busy_a", 16'(busy_a), 16'd0);
      chk("rst_data_a", data_a, BUS_Z);
      chk("rst_busy_b", 16'(busy_b), 16'd0);
      chk("rst_data_b", data_b, BUS_Z);
    end

    // Chip enable alone starts nothing.
    ce_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("ce_only_busy_a", 16'(busy_a), 16'd0);
      chk("ce_only_busy_b", 16'(busy_b), 16'd0);
    end
    strobes_off();
    @(negedge clk);

    wr(20'h00012, 16'hBEEF, 1'b0, 1'b0);
    rd(20'h00012, 1'b0, 1'b0, 16'hBEEF);

    wr(20'h00012, 16'h1234, 1'b1, 1'b0);
    rd(20'h00012, 1'b0, 1'b0, 16'hBE34);
    rd(20'h00012, 1'b1, 1'b0, 16'h0034);

    wr(20'h00003, 16'h00A5, 1'b0, 1'b0);
    rd(20'h00103, 1'b0, 1'b0, 16'h00A5);

    // Read aborted while waiting: bus never driven.
    addr = 20'h00012; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1;
    @(negedge clk);
    chk("abort_wait_busy_a", 16'(busy_a), 16'd1);
    oe_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_busy_a", 16'(busy_a), 16'd0);
      chk("abort_r_a", 16'(r_a), 16'd0);
      chk("abort_data_a", data_a, BUS_Z);
      chk("abort_data_b", data_b, BUS_Z);
    end
    strobes_off();
    @(negedge clk);

    // Reset on the commit edge of a write.
    addr = 20'h00012; tb_val = 16'h5555; tb_en = 1'b1; ub_n = 1'b0; lb_n = 1'b0;
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1;
    @(negedge clk);
    chk("rstwr_r_a", 16'(r_a), 16'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstwr_busy_a", 16'(busy_a), 16'd0);
    chk("rstwr_r_a_off", 16'(r_a), 16'd0);
    chk("rstwr_busy_b", 16'(busy_b), 16'd0);
    rst = 1'b0;
    strobes_off();
    @(negedge clk);
    rd(20'h00012, 1'b0, 1'b0, 16'hBE34);

    // WE_N falling during a driven read releases the bus at once.
    addr = 20'h00003; ub_n = 1'b0; lb_n = 1'b0; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("cont_drive_a", data_a, 16'h00A5);
    we_n = 1'b0;
    #1;
    chk("cont_release_a", data_a, BUS_Z);
    @(negedge clk);
    chk("cont_r_a", 16'(r_a), 16'd0);
    chk("cont_busy_a", 16'(busy_a), 16'd1);
    chk("cont_data_a", data_a, BUS_Z);
    strobes_off();
    @(negedge clk);
    chk("cont_idle_a", 16'(busy_a), 16'd0);
    chk("cont_idle_b", 16'(busy_b), 16'd0);
    rd(20'h00003, 1'b0, 1'b0, 16'h00A5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
